// File: rtl/pg_guard_ctrl_pkg.sv
// Shared state encodings and default timing constants for the PG guard sequencer.
package pg_guard_ctrl_pkg;

  typedef enum logic [2:0] {
    S_ACTIVE  = 3'd0,
    S_QUIESCE = 3'd1,
    S_GUARD   = 3'd2,
    S_STANDBY = 3'd3,
    S_RELEASE = 3'd4,
    S_UNGUARD = 3'd5
  } pg_state_e;

  localparam logic [2:0] ST_ACTIVE  = S_ACTIVE;
  localparam logic [2:0] ST_QUIESCE = S_QUIESCE;
  localparam logic [2:0] ST_GUARD   = S_GUARD;
  localparam logic [2:0] ST_STANDBY = S_STANDBY;
  localparam logic [2:0] ST_RELEASE = S_RELEASE;
  localparam logic [2:0] ST_UNGUARD = S_UNGUARD;

  localparam int unsigned SETUP_CYC_DEF   = 4;
  localparam int unsigned WAKE_CYC_DEF    = 8;
  localparam int unsigned HOLD_CYC_DEF    = 2;
  localparam int unsigned ACK_TIMEOUT_DEF = 255;
  localparam int unsigned CNT_W_DEF       = 8;

endpackage

// File: rtl/pg_guard_ctrl_cnt.sv
// Loadable down-counter for the sequencer's settle delays; holds at zero.
module pg_guard_cnt
  import pg_guard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pg_guard_ctrl.sv
// Standby entry/exit sequencer for the PG guard cells' E pin.
// Optional quiesce-ack timeout is enabled by defining PG_GUARD_CTRL_TIMEOUT_EN.
module pg_guard_ctrl
  import pg_guard_ctrl_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = SETUP_CYC_DEF,
  parameter int unsigned WAKE_CYC    = WAKE_CYC_DEF,
  parameter int unsigned HOLD_CYC    = HOLD_CYC_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       STDBY_REQ,
  input  logic       WAKE_REQ,
  input  logic       QUIESCE_ACK,
  output logic       QUIESCE_REQ,
  output logic       PG_E,
  output logic       STDBY_O,
  output logic       READY,
  output logic [2:0] STATE,
  output logic       TIMEOUT
);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_WAKE  = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_ACK   = CNT_W'(ACK_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic             qreq_q, qreq_d, pge_q, pge_d, stdby_q, stdby_d, ready_q, ready_d;
  logic             cnt_load, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             to_set;

  always_comb begin
    state_d = state_q;
    to_set  = 1'b0;
    case (state_q)
      ST_ACTIVE:  if (STDBY_REQ && !WAKE_REQ) state_d = ST_QUIESCE;
      ST_QUIESCE: begin
        if (WAKE_REQ)         state_d = ST_ACTIVE;
        else if (QUIESCE_ACK) state_d = ST_GUARD;
`ifdef PG_GUARD_CTRL_TIMEOUT_EN
        else if (cnt_zero) begin
          state_d = ST_GUARD;
          to_set  = 1'b1;
        end
`endif
      end
      ST_GUARD: begin
        if (WAKE_REQ)      state_d = ST_UNGUARD;
        else if (cnt_zero) state_d = ST_STANDBY;
      end
      ST_STANDBY: if (WAKE_REQ) state_d = ST_RELEASE;
      ST_RELEASE: if (cnt_zero) state_d = ST_UNGUARD;
      ST_UNGUARD: if (cnt_zero) state_d = ST_ACTIVE;
      default:    state_d = ST_ACTIVE;
    endcase
  end

  // Every timed state reloads on entry, so a stale count never leaks across states.
  always_comb begin
    cnt_load = (state_d != state_q);
    case (state_d)
      ST_QUIESCE: cnt_val = LD_ACK;
      ST_GUARD:   cnt_val = LD_SETUP;
      ST_RELEASE: cnt_val = LD_WAKE;
      ST_UNGUARD: cnt_val = LD_HOLD;
      default:    cnt_val = '0;
    endcase
  end

  // Outputs decode the next state so they flip on the same edge as STATE.
  always_comb begin
    qreq_d  = 1'b1;
    pge_d   = 1'b0;
    stdby_d = 1'b0;
    ready_d = 1'b0;
    case (state_d)
      ST_ACTIVE:  begin qreq_d = 1'b0; ready_d = 1'b1; end
      ST_GUARD,
      ST_RELEASE: pge_d = 1'b1;
      ST_STANDBY: begin pge_d = 1'b1; stdby_d = 1'b1; end
      default:    ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_ACTIVE;
      qreq_q  <= 1'b0;
      pge_q   <= 1'b0;
      stdby_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      qreq_q  <= qreq_d;
      pge_q   <= pge_d;
      stdby_q <= stdby_d;
      ready_q <= ready_d;
    end
  end

`ifdef PG_GUARD_CTRL_TIMEOUT_EN
  logic to_q;
  always_ff @(posedge CLK) begin
    if (RST)         to_q <= 1'b0;
    else if (to_set) to_q <= 1'b1;
  end
  assign TIMEOUT = to_q;
`else
  logic unused_to;
  assign unused_to = to_set;
  assign TIMEOUT   = 1'b0;
`endif

  pg_guard_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  assign STATE       = state_q;
  assign QUIESCE_REQ = qreq_q;
  assign PG_E        = pge_q;
  assign STDBY_O     = stdby_q;
  assign READY       = ready_q;

endmodule

// File: doc/pg_guard_ctrl.md
Name: pg_guard_ctrl

Overview:
Sequencer driving the E (guard-enable) pin of a bank of power-guard input cells, upstream of them. It sequences standby entry and exit: quiesce the core, assert the guard, assert standby, then release in reverse order with programmable settle delays. All outputs are registered, so the guard pins see glitch-free levels.

Parameters:
SETUP_CYC, 4, cycles PG_E is held high before STDBY_O asserts (>=1)
WAKE_CYC, 8, cycles after STDBY_O deasserts before PG_E releases (>=1)
HOLD_CYC, 2, cycles after PG_E releases before READY returns (>=1)
ACK_TIMEOUT, 255, maximum cycles spent waiting for QUIESCE_ACK (used only with the optional feature)
CNT_W, 8, width of the delay counter; every *_CYC value must be <= 2**CNT_W

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
STDBY_REQ  in  1  level request to enter standby
WAKE_REQ  in  1  level request to leave standby; has priority over STDBY_REQ
QUIESCE_ACK  in  1  core reports it is idle and its inputs may be frozen
QUIESCE_REQ  out  1  asks the core to quiesce
PG_E  out  1  guard enable to the PG cells' E pin (1 = guarded, output pulled low)
STDBY_O  out  1  standby request to the power controller
READY  out  1  high only in ACTIVE
STATE  out  3  current state encoding (debug)
TIMEOUT  out  1  sticky: quiesce ack timed out

Behaviour:
- Clock and reset: single clock CLK. RST is synchronous and active-high.
- Reset values: state ACTIVE, QUIESCE_REQ=0, PG_E=0, STDBY_O=0, READY=1, TIMEOUT=0, counter=0. RST asserted in any state returns to these values on the next edge, mid-sequence included.
- State encoding: ACTIVE=0, QUIESCE=1, GUARD=2, STANDBY=3, RELEASE=4, UNGUARD=5.
- Outputs are registered and decoded from the next state, so they change on the same edge as STATE.
- Counter: loaded with N-1 on entry to a timed state. The state lasts exactly N cycles and exits on the edge where counter==0.
- ACTIVE: STDBY_REQ=1 and WAKE_REQ=0 -> QUIESCE. If both are high, stay in ACTIVE.
- QUIESCE: QUIESCE_REQ=1, PG_E=0.
  - WAKE_REQ=1 -> ACTIVE (abort; WAKE_REQ has priority over QUIESCE_ACK in the same cycle).
  - Otherwise QUIESCE_ACK=1 -> GUARD.
- GUARD: PG_E=1, QUIESCE_REQ=1, lasts SETUP_CYC cycles.
  - WAKE_REQ=1 -> UNGUARD immediately. STDBY_O is never asserted on this path.
  - Otherwise, when the count expires -> STANDBY.
- STANDBY: PG_E=1, STDBY_O=1, QUIESCE_REQ=1. WAKE_REQ=1 -> RELEASE. STDBY_REQ is ignored.
- RELEASE: STDBY_O=0, PG_E=1, lasts WAKE_CYC cycles, then -> UNGUARD. WAKE_REQ is ignored.
- UNGUARD: PG_E=0, QUIESCE_REQ=1, lasts HOLD_CYC cycles, then -> ACTIVE. QUIESCE_REQ drops on entry to ACTIVE.
- Invariants:
  - STDBY_O=1 implies PG_E=1.
  - PG_E never falls in the same cycle STDBY_O falls.
  - QUIESCE_REQ covers the whole PG_E=1 window.
- STDBY_REQ held high after wake: a new entry starts from ACTIVE one cycle later, so READY pulses high for at least one cycle.

Optional Feature:
PG_GUARD_CTRL_TIMEOUT_EN
- Defined:
  - In QUIESCE, the counter is loaded with ACK_TIMEOUT-1.
  - If the count expires without an ack, go to GUARD anyway and set TIMEOUT=1.
  - TIMEOUT stays set until RST.
- Undefined: QUIESCE waits indefinitely for QUIESCE_ACK. TIMEOUT is tied to 0 and ACK_TIMEOUT is unused.

Decomposition:
- Package pg_guard_ctrl_pkg: state enum with the fixed 3-bit encodings above, and the default cycle constants.
- One sub-module, pg_guard_cnt: loadable down-counter with ports load, load_val[CNT_W], zero flag.
- The FSM and output registers stay in the top module.

Test Plan:
1. Reset, then STDBY_REQ=1 with QUIESCE_ACK returned 3 cycles later -> PG_E rises one cycle after the ack is sampled; STDBY_O rises exactly 4 cycles after PG_E (SETUP_CYC=4).
2. In STANDBY, pulse WAKE_REQ for 1 cycle -> STDBY_O falls next edge; PG_E falls 8 cycles later; READY rises 2 cycles after that.
3. WAKE_REQ asserted on the 2nd cycle of GUARD -> STATE goes to UNGUARD, STDBY_O stays 0 throughout, READY=1 after 2 cycles.
4. STDBY_REQ and WAKE_REQ both high in ACTIVE for 10 cycles -> STATE stays 0, all outputs at reset values.
5. RST asserted for 1 cycle in STANDBY -> next edge PG_E=0, STDBY_O=0, READY=1, STATE=0.
6. With PG_GUARD_CTRL_TIMEOUT_EN, ACK_TIMEOUT=16, QUIESCE_ACK held 0 -> GUARD entered after 16 cycles, TIMEOUT=1 and still 1 after the full wake sequence.
